// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request side: floor encodings, panel
// states, travel direction and the nearest-call search used by the panel.
package elevator_pkg;

  localparam logic [2:0] FL1 = 3'b001;
  localparam logic [2:0] FL2 = 3'b010;
  localparam logic [2:0] FL3 = 3'b100;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_OPEN  = 2'd2,
    WAIT_CLOSE = 2'd3
  } panel_state_e;

  // Nearest pending floor strictly beyond curIdx in the given direction,
  // optionally also accepting the current floor itself.
  function automatic logic [2:0] nearestCall(input logic [2:0] lamp,
                                             input logic [1:0] curIdx,
                                             input logic       up,
                                             input logic       inclCur);
    logic [2:0] pick;
    logic       inRange;
    pick = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == int'(curIdx)) begin
        inRange = inclCur;
      end else if (up) begin
        inRange = (i > int'(curIdx));
      end else begin
        inRange = (i < int'(curIdx));
      end
      if (lamp[i] && inRange && (!up || pick == 3'b000)) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/call_debounce.sv
// One floor-call button: two-flop synchroniser, stable-sample debounce and a
// single-cycle pulse when the accepted level rises.
module call_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // The level flips on the DEB_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/elevator_call_panel.sv
// Request side of the 3-floor elevator: latches debounced calls as lamps and
// hands them one at a time to the controller, watching FLRn/Door for service.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:1] Btn,
  input  logic       FLR1,
  input  logic       FLR2,
  input  logic       FLR3,
  input  logic       Door,
  output logic [3:1] Req,
  output logic [3:1] Lamp,
  output logic       Fault
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]   w_rise;
  logic [2:0]   w_flr;
  logic [2:0]   w_press;
  logic [2:0]   w_clr;
  logic [2:0]   w_selSame;
  logic [2:0]   w_selFlip;
  logic [2:0]   w_lampNext;
  logic [2:0]   w_reqNext;
  logic [2:0]   w_tgtNext;
  logic         w_dirNext;
  logic         w_faultNext;
  logic [7:0]   w_tmoNext;
  panel_state_e w_stateNext;

  logic [2:0]   r_lamp;
  logic [2:0]   r_req;
  logic [2:0]   r_tgt;
  logic [1:0]   r_curIdx;
  logic         r_dir;
  logic         r_fault;
  logic [7:0]   r_tmo;
  panel_state_e r_state;

  for (genvar g = 0; g < 3; g++) begin : g_deb
    call_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (Reset),
      .i_btn (Btn[g+1]),
      .o_rise(w_rise[g])
    );
  end

  assign w_flr     = {FLR3, FLR2, FLR1};
  assign w_press   = w_rise & ~(w_flr & {3{Door}});
  assign w_selSame = nearestCall(r_lamp, r_curIdx, r_dir, 1'b1);
  assign w_selFlip = nearestCall(r_lamp, r_curIdx, ~r_dir, 1'b0);

  // Position only moves on an unambiguous floor indication.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_curIdx <= 2'd0;
    end else begin
      case (w_flr)
        FL1:     r_curIdx <= 2'd0;
        FL2:     r_curIdx <= 2'd1;
        FL3:     r_curIdx <= 2'd2;
        default: r_curIdx <= r_curIdx;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_lamp  <= '0;
      r_req   <= '0;
      r_tgt   <= FL1;
      r_dir   <= UP;
      r_fault <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_lamp  <= w_lampNext;
      r_req   <= w_reqNext;
      r_tgt   <= w_tgtNext;
      r_dir   <= w_dirNext;
      r_fault <= w_faultNext;
      r_tmo   <= w_tmoNext;
    end
  end

  // The timeout fires on the cycle the wait count reaches TIMEOUT; a service
  // seen on that same cycle takes precedence.
  always_comb begin
    w_stateNext = r_state;
    w_reqNext   = r_req;
    w_tgtNext   = r_tgt;
    w_dirNext   = r_dir;
    w_faultNext = r_fault;
    w_tmoNext   = r_tmo;
    w_clr       = '0;
    case (r_state)
      IDLE: begin
        w_reqNext = '0;
        if (r_lamp != 3'b000) begin
          if (w_selSame != 3'b000) begin
            w_tgtNext = w_selSame;
          end else begin
            w_tgtNext = w_selFlip;
            w_dirNext = ~r_dir;
          end
          w_reqNext   = w_tgtNext;
          w_tmoNext   = '0;
          w_stateNext = ISSUE;
        end
      end
      ISSUE, WAIT_OPEN: begin
        if (r_state == WAIT_OPEN) begin
          w_reqNext = '0;
        end
        if (r_state == ISSUE && (w_flr & r_tgt) != 3'b000 && Door) begin
          w_clr       = r_tgt;
          w_reqNext   = '0;
          w_stateNext = WAIT_CLOSE;
        end else if (r_tmo == TMO_LAST) begin
          w_faultNext = 1'b1;
          w_clr       = r_tgt;
          w_reqNext   = '0;
          w_stateNext = IDLE;
        end else begin
          w_tmoNext = r_tmo + 8'd1;
          if (r_state == ISSUE && Door) begin
            w_reqNext   = '0;
            w_stateNext = WAIT_OPEN;
          end else if (r_state == WAIT_OPEN && !Door) begin
            w_reqNext   = r_tgt;
            w_stateNext = ISSUE;
          end
        end
      end
      WAIT_CLOSE: begin
        w_reqNext = '0;
        if (!Door) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_reqNext   = '0;
        w_stateNext = IDLE;
      end
    endcase
    w_lampNext = (r_lamp | w_press) & ~w_clr;
  end

  assign Req   = r_req;
  assign Lamp  = r_lamp;
  assign Fault = r_fault;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Self-checking bench for elevator_call_panel: table of target-selection
// vectors from reset, then hand-written multi-cycle service sequences.
module tb_elevator_call_panel;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:1] Btn = '0;
  logic       FLR1 = 1'b0;
  logic       FLR2 = 1'b0;
  logic       FLR3 = 1'b0;
  logic       Door = 1'b0;
  logic [3:1] Req;
  logic [3:1] Lamp;
  logic       Fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] flr;
    logic       door;
    logic [2:0] press;
    logic [2:0] expLamp;
    logic [2:0] expReq;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  elevator_call_panel dut (
    .clk  (clk),
    .Reset(Reset),
    .Btn  (Btn),
    .FLR1 (FLR1),
    .FLR2 (FLR2),
    .FLR3 (FLR3),
    .Door (Door),
    .Req  (Req),
    .Lamp (Lamp),
    .Fault(Fault)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic doReset();
    Reset = 1'b0;
    Btn   = '0;
    {FLR3, FLR2, FLR1} = 3'b000;
    Door  = 1'b0;
    step(2);
    Reset = 1'b1;
    step(1);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    doReset();
    {FLR3, FLR2, FLR1} = v.flr;
    Door = v.door;
    step(1);
    Btn = v.press;
    step(7);
    checkOutput($sformatf("vec%0d_lamp", idx), {5'b0, Lamp}, {5'b0, v.expLamp});
    Btn = '0;
    step(1);
    checkOutput($sformatf("vec%0d_req", idx), {5'b0, Req}, {5'b0, v.expReq});
  endtask

  initial begin
    // Fresh reset each vector, so dir starts UP and the car sits at flr.
    vecs[0] = '{3'b001, 1'b0, 3'b010, 3'b010, 3'b010};
    vecs[1] = '{3'b001, 1'b0, 3'b110, 3'b110, 3'b010};
    vecs[2] = '{3'b010, 1'b0, 3'b011, 3'b011, 3'b010};
    vecs[3] = '{3'b010, 1'b0, 3'b101, 3'b101, 3'b100};
    vecs[4] = '{3'b100, 1'b0, 3'b001, 3'b001, 3'b001};
    vecs[5] = '{3'b100, 1'b0, 3'b011, 3'b011, 3'b010};
    vecs[6] = '{3'b001, 1'b0, 3'b100, 3'b100, 3'b100};
    vecs[7] = '{3'b010, 1'b0, 3'b001, 3'b001, 3'b001};
    vecs[8] = '{3'b001, 1'b1, 3'b001, 3'b000, 3'b000};

    // Idle after reset with no buttons.
    doReset();
    for (int c = 0; c < 50; c++) begin
      checkOutput("idle_outputs", {1'b0, Req, Lamp, Fault}, 8'h00);
      step(1);
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Floor-3 call from floor 1, latency and service.
    doReset();
    FLR1 = 1'b1;
    step(1);
    Btn = 3'b100;
    step(6);
    checkOutput("t2_lamp_early", {5'b0, Lamp}, 8'h00);
    step(1);
    checkOutput("t2_lamp", {5'b0, Lamp}, 8'h04);
    checkOutput("t2_req_early", {5'b0, Req}, 8'h00);
    step(1);
    checkOutput("t2_req", {5'b0, Req}, 8'h04);
    step(2);
    Btn = '0;
    checkOutput("t2_req_hold", {5'b0, Req}, 8'h04);
    FLR1 = 1'b0;
    FLR3 = 1'b1;
    Door = 1'b1;
    step(1);
    checkOutput("t2_served", {2'b0, Req, Lamp}, 8'h00);
    Door = 1'b0;
    step(3);
    checkOutput("t2_after_close", {1'b0, Req, Lamp, Fault}, 8'h00);

    // Short glitch on floor 1 must not register.
    Btn = 3'b001;
    step(3);
    Btn = '0;
    step(10);
    checkOutput("t3_glitch_lamp", {5'b0, Lamp}, 8'h00);

    // Car at floor 2 heading up, calls at 1 and 3.
    FLR3 = 1'b0;
    FLR2 = 1'b1;
    step(1);
    Btn = 3'b101;
    step(7);
    checkOutput("t4_lamp", {5'b0, Lamp}, 8'h05);
    Btn = '0;
    step(1);
    checkOutput("t4_req_first", {5'b0, Req}, 8'h04);
    FLR2 = 1'b0;
    FLR3 = 1'b1;
    Door = 1'b1;
    step(1);
    checkOutput("t4_served3", {2'b0, Req, Lamp}, 8'h01);
    Door = 1'b0;
    step(1);
    checkOutput("t4_gap", {5'b0, Req}, 8'h00);
    step(1);
    checkOutput("t4_req_second", {5'b0, Req}, 8'h01);
    FLR3 = 1'b0;
    FLR1 = 1'b1;
    Door = 1'b1;
    step(1);
    checkOutput("t4_served1", {2'b0, Req, Lamp}, 8'h00);
    Door = 1'b0;
    step(2);

    // Floor-2 call never answered: timeout.
    Btn = 3'b010;
    step(7);
    Btn = '0;
    step(1);
    checkOutput("t5_req", {5'b0, Req}, 8'h02);
    step(254);
    checkOutput("t5_no_fault_yet", {4'b0, Req, Fault}, 8'h04);
    step(1);
    checkOutput("t5_fault", {1'b0, Req, Lamp, Fault}, 8'h01);
    step(5);
    checkOutput("t5_fault_sticky", {1'b0, Req, Lamp, Fault}, 8'h01);

    // Async reset in the middle of ISSUE.
    Btn = 3'b100;
    step(7);
    Btn = '0;
    step(1);
    checkOutput("t6_req_before", {5'b0, Req}, 8'h04);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("t6_async_clear", {1'b0, Req, Lamp, Fault}, 8'h00);
    step(2);
    Reset = 1'b1;
    step(1);
    FLR1 = 1'b1;
    Door = 1'b1;
    Btn  = 3'b001;
    step(10);
    Btn = '0;
    step(5);
    checkOutput("t6_suppressed", {2'b0, Req, Lamp}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
